// File: rtl/booth_mac_accumulator.sv
// booth_mac_accumulator: sums a programmed number of signed products and emits the saturated result
//   clk, reset        : clock (posedge) and synchronous active-high reset
//   start, len        : begin a run of len products (sampled only when idle)
//   in_valid/in_ready : product stream handshake, in_data is a signed PW-bit product
//   out_valid/out_ready : result handshake, out_data is the saturated sum, out_sat flags clipping
//   busy              : a run is in progress or a result is waiting
module booth_mac_accumulator #(
   parameter int PW = 32,
   parameter int AW = 40,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [CW-1:0] len,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] out_data,
   output logic          out_sat,
   output logic          busy
);
   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
   state_t state, state_n;
   logic [AW-1:0] acc;
   logic [CW-1:0] cnt, len_q;
   logic [AW-PW:0] top;
   logic fire;
   assign in_ready  = (state == ACC);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign fire      = in_valid & in_ready;
   // acc fits in PW bits only when every bit from PW-1 upward is a copy of the sign
   assign top      = acc[AW-1:PW-1];
   assign out_sat  = ~(&top | ~|top);
   assign out_data = out_sat ? (acc[AW-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}})
                             : acc[PW-1:0];
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = start ? ((len == '0) ? DONE : ACC) : IDLE;
         ACC:     state_n = (fire && (cnt + CW'(1) == len_q)) ? DONE : ACC;
         DONE:    state_n = out_ready ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         len_q <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && start) begin
            len_q <= len;
            acc   <= '0;
            cnt   <= '0;
         end
         if (fire) begin
            acc <= acc + {{(AW-PW){in_data[PW-1]}}, in_data};
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_booth_mac_accumulator.sv
// tb_booth_mac_accumulator: directed runs checked against a behavioural MAC model
module tb_booth_mac_accumulator;
   logic        clk = 0;
   logic        reset = 1;
   logic        start = 0;
   logic [7:0]  len = 0;
   logic        in_valid = 0;
   logic        in_ready;
   logic [31:0] in_data = 0;
   logic        out_valid;
   logic        out_ready = 0;
   logic [31:0] out_data;
   logic        out_sat;
   logic        busy;
   int errors = 0;
   int checks = 0;
   booth_mac_accumulator dut (
      .clk(clk), .reset(reset), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sat(out_sat), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   function automatic logic [32:0] sat(input longint s);
      logic [63:0] u;
      u = s;
      if (s > 64'sd2147483647) return {1'b1, 32'h7FFFFFFF};
      if (s < -64'sd2147483648) return {1'b1, 32'h80000000};
      return {1'b0, u[31:0]};
   endfunction
   // model: collecting products, or holding a finished sum, or idle
   bit     m_in, m_out;
   int     m_left;
   longint m_sum;
   always @(posedge clk) begin
      if (reset) begin
         m_in <= 0; m_out <= 0; m_left <= 0; m_sum <= 0;
      end else if (m_out) begin
         if (out_ready) m_out <= 0;
      end else if (m_in) begin
         if (in_valid) begin
            m_sum  <= m_sum + longint'($signed(in_data));
            m_left <= m_left - 1;
            if (m_left == 1) begin m_in <= 0; m_out <= 1; end
         end
      end else if (start) begin
         m_sum  <= 0;
         m_left <= int'(len);
         if (len == 0) m_out <= 1; else m_in <= 1;
      end
   end
   always @(negedge clk) begin
      if (!reset) begin
         chk("in_ready", in_ready, m_in);
         chk("out_valid", out_valid, m_out);
         chk("busy", busy, m_in | m_out);
         if (m_out) chk("model_result", {out_sat, out_data}, sat(m_sum));
      end
   end
   logic [31:0] dq[$];
   bit          vq[$];
   int          rdy;
   task automatic run(input int l, input int hold, input logic [31:0] exp_d,
                      input logic exp_s, input int exp_lat);
      int n, idx, p;
      bit v;
      n = 0; idx = 0; p = 0; rdy = 0;
      @(negedge clk);
      start = 1; len = 8'(l); in_valid = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         start = 0;
         n++;
         if (out_valid) break;
         rdy += int'(in_ready);
         v = (vq.size() == 0) ? (idx < dq.size()) : (p < vq.size() ? vq[p] : 1'b0);
         in_valid = v;
         in_data  = (idx < dq.size()) ? dq[idx] : 32'hDEADBEEF;
         if (v && in_ready) idx++;
         p++;
      end
      in_valid = 0;
      chk("latency", n, exp_lat);
      chk("out_data", out_data, exp_d);
      chk("out_sat", out_sat, exp_s);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         start = ~start; len = 8'd1; in_valid = 1; in_data = 32'h11111111;
         chk("hold_data", out_data, exp_d);
         chk("hold_valid", out_valid, 1);
         chk("hold_ready", in_ready, 0);
      end
      @(negedge clk);
      start = 0; in_valid = 0; out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk("idle_after", busy, 0);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      reset = 0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_busy", busy, 0);
      dq = '{32'h64}; vq = '{};
      run(1, 0, 32'h64, 0, 2);
      dq = '{32'd7, -32'sd3, 32'd10, -32'sd20};
      run(4, 0, 32'hFFFFFFFA, 0, 5);
      chk("ready_cycles", rdy, 4);
      dq = '{32'h7FFFFFFF, 32'h7FFFFFFF};
      run(2, 0, 32'h7FFFFFFF, 1, 3);
      dq = '{32'h80000000, 32'h80000000};
      run(2, 0, 32'h80000000, 1, 3);
      dq = '{32'd5, 32'd6, 32'd7}; vq = '{1, 0, 0, 1, 0, 1};
      run(3, 5, 32'd18, 0, 7);
      dq = '{}; vq = '{};
      run(0, 0, 32'd0, 0, 1);
      chk("len0_ready", rdy, 0);
      @(negedge clk);
      start = 1; len = 8'd4;
      @(negedge clk);
      start = 0; in_valid = 1; in_data = 32'd11;
      @(negedge clk);
      in_data = 32'd22;
      @(negedge clk);
      in_valid = 0; reset = 1;
      @(negedge clk);
      reset = 0;
      chk("mid_rst_ready", in_ready, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_sat", out_sat, 0);
      chk("mid_rst_busy", busy, 0);
      dq = '{32'd1, 32'd2};
      run(2, 0, 32'd3, 0, 3);
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
